systolic_array_sequencer: RTL and testbench
===========================================

// Module: systolic_array_sequencer
// PURPOSE
//  Job-level controller for the N x N weight-stationary systolic array. Accepts a command,
//  optionally loads a new weight matrix, then streams cmd_num_vecs input vectors through the
//  array one at a time and returns one N-element result vector per input.
//  Sits between the upstream softmax/matmul datapath (valid/ready streams) and the array's
//  load_weights/start/x_in/w_in/y_out/done pins.
// PARAMETERS
//  DATA_WIDTH  32   element width; must match the array instance
//  N           4    array dimension (rows = cols)
//  ARRAY_LAT   8    cycles start is held high per vector; must be >= 2*N
//  CNT_W       16   width of the vector-count field
// PORTS
//  clk               in   1             rising-edge clock
//  reset             in   1             synchronous, active-high reset
//  cmd_valid         in   1             command offered
//  cmd_ready         out  1             high only in IDLE
//  cmd_load_w        in   1             1 = load a weight matrix before streaming
//  cmd_num_vecs      in   CNT_W         number of input vectors in the job (0 allowed)
//  w_valid/w_ready   in/out 1           weight-matrix handshake
//  w_data            in   N*N*DATA_WIDTH  element (i,j) at [(i*N+j)*DATA_WIDTH +: DATA_WIDTH]
//  x_valid/x_ready   in/out 1           input-vector handshake
//  x_data            in   N*DATA_WIDTH  element i at [i*DATA_WIDTH +: DATA_WIDTH]
//  y_valid/y_ready   out/in 1           result-vector handshake
//  y_data            out  N*DATA_WIDTH  result element k at [k*DATA_WIDTH +: DATA_WIDTH]
//  arr_load_weights  out  1             to array load_weights
//  arr_start         out  1             to array start
//  arr_w             out  N*N*DATA_WIDTH  to array w_in (held between loads)
//  arr_x             out  N*DATA_WIDTH  to array x_in (held during COMPUTE)
//  arr_y             in   N*DATA_WIDTH  from array y_out
//  arr_done          in   1             from array done
//  busy              out  1             state != IDLE
//  job_done          out  1             one-cycle pulse at job completion
//  err               out  1             sticky: arr_done low in CAPTURE
// BEHAVIOUR
//  Reset (sync, high): state=IDLE; all outputs 0 except cmd_ready=1; arr_w, arr_x, y_data,
//    remaining count cleared. Reset mid-job aborts the job; no job_done; pending y dropped.
//  States: IDLE, LOAD_W, WLATCH, WAIT_X, COMPUTE, CAPTURE, OUT, DONE.
//  IDLE: cmd_ready=1. On cmd handshake latch num_vecs -> remaining.
//    load_w=1 -> LOAD_W; else remaining==0 -> DONE; else -> WAIT_X.
//  LOAD_W: w_ready=1. On handshake arr_w<=w_data, -> WLATCH.
//  WLATCH: arr_load_weights=1 for exactly this cycle; -> WAIT_X (remaining!=0) or DONE.
//  WAIT_X: x_ready=1. On handshake arr_x<=x_data, cycle counter<=ARRAY_LAT-1, -> COMPUTE.
//  COMPUTE: arr_start=1; counter decrements; at counter==0 -> CAPTURE (start high exactly
//    ARRAY_LAT cycles). arr_x stable throughout.
//  CAPTURE: arr_start=0; y_data<=arr_y, y_valid<=1; err<=err|~arr_done; -> OUT.
//  OUT: y_valid held, y_data stable until y_ready. On handshake y_valid<=0, remaining-=1;
//    remaining becomes 0 -> DONE else -> WAIT_X.
//  DONE: job_done=1 for one cycle; -> IDLE.
//  Latency: y_valid visible after the (ARRAY_LAT+1)th rising edge following the x handshake
//    edge. Throughput: one vector per ARRAY_LAT+3 cycles min (WAIT_X, COMPUTE, CAPTURE, OUT).
//  x_ready/w_ready/cmd_ready are pure state decodes; never depend on their own valid.
//  cmd_valid while busy is ignored (not consumed). y_ready with y_valid low has no effect.
//  arr_load_weights and arr_start never high in the same cycle.
//  remaining counter never wraps: decremented only in OUT with remaining>=1.
//  cmd_num_vecs=0, load_w=0 -> job_done pulses 2 cycles after cmd handshake, no array activity.
//  err cleared only by reset.
// STRUCTURE
//  Package systolic_ctrl_pkg: state enum typedef, default DATA_WIDTH/N/ARRAY_LAT localparams,
//    lane-select helper function for packed buses. No sub-module: FSM, counter and output
//    register fit in one module.
// TESTING (N=4, DATA_WIDTH=32, ARRAY_LAT=8; bench checks y against y[k]=sum_i x[i]*W[i][k])
//  1 cmd(load_w=1,num=1), W=identity, x=[1,2,3,4] -> one arr_load_weights pulse, start high
//    exactly 8 cycles, y=[1,2,3,4], y_valid 9 edges after x handshake, then job_done.
//  2 cmd(load_w=0,num=3), W reused (all 2s), x=[1,1,1,1],[0,0,0,5],[3,0,0,0] -> y all-8,
//    all-10, all-6 in order; no arr_load_weights pulse.
//  3 y_ready held low 20 cycles in test 2 -> y_data stable, x_ready low, no extra start.
//  4 cmd(load_w=0,num=0) -> job_done 2 cycles after handshake; arr_start never high.
//  5 reset asserted mid-COMPUTE of vector 2 -> next cycle all outputs reset, no job_done;
//    a fresh cmd afterward completes normally.
//  6 cmd_valid pulsed while busy -> ignored; arr_done forced low in CAPTURE -> err=1, sticky.

Source files
------------

// File: rtl/systolic_ctrl_pkg.sv
// Shared types and defaults for the systolic-array job sequencer.
// Holds the FSM state enum, default sizing and a lane-select helper for packed buses.
package systolic_ctrl_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefN         = 4;
    localparam int unsigned DefArrayLat  = 8;
    localparam int unsigned DefCntW      = 16;

    // Widest packed bus the helper accepts: a full default weight matrix.
    localparam int unsigned LaneBusW = DefN * DefN * DefDataWidth;

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StWlatch,
        StWaitX,
        StCompute,
        StCapture,
        StOut,
        StDone
    } state_e;

    function automatic logic [DefDataWidth-1:0] lane_sel(input logic [LaneBusW-1:0] bus,
                                                         input int unsigned idx);
        return DefDataWidth'(bus >> (idx * DefDataWidth));
    endfunction

endpackage

// File: rtl/systolic_array_sequencer.sv
// Job-level controller for an N x N weight-stationary systolic array: optional weight load,
// then one x vector in / one y vector out per array pass.
module systolic_array_sequencer
    import systolic_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned N          = DefN,
    parameter int unsigned ARRAY_LAT  = DefArrayLat,
    parameter int unsigned CNT_W      = DefCntW
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_cmd_valid,
    output logic                           o_cmd_ready,
    input  logic                           i_cmd_load_w,
    input  logic [CNT_W-1:0]               i_cmd_num_vecs,
    input  logic                           i_w_valid,
    output logic                           o_w_ready,
    input  logic [N*N*DATA_WIDTH-1:0]      i_w_data,
    input  logic                           i_x_valid,
    output logic                           o_x_ready,
    input  logic [N*DATA_WIDTH-1:0]        i_x_data,
    output logic                           o_y_valid,
    input  logic                           i_y_ready,
    output logic [N*DATA_WIDTH-1:0]        o_y_data,
    output logic                           o_arr_load_weights,
    output logic                           o_arr_start,
    output logic [N*N*DATA_WIDTH-1:0]      o_arr_w,
    output logic [N*DATA_WIDTH-1:0]        o_arr_x,
    input  logic [N*DATA_WIDTH-1:0]        i_arr_y,
    input  logic                           i_arr_done,
    output logic                           o_busy,
    output logic                           o_job_done,
    output logic                           o_err
);

    localparam int unsigned LatW = (ARRAY_LAT > 2) ? $clog2(ARRAY_LAT) : 1;

    state_e                      r_state;
    logic [CNT_W-1:0]            r_remaining;
    logic [LatW-1:0]             r_cnt;
    logic [N*N*DATA_WIDTH-1:0]   r_arr_w;
    logic [N*DATA_WIDTH-1:0]     r_arr_x;
    logic [N*DATA_WIDTH-1:0]     r_y_data;
    logic                        r_y_valid;
    logic                        r_err;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_cnt       <= '0;
            r_arr_w     <= '0;
            r_arr_x     <= '0;
            r_y_data    <= '0;
            r_y_valid   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_cmd_valid) begin
                        r_remaining <= i_cmd_num_vecs;
                        if (i_cmd_load_w) begin
                            r_state <= StLoadW;
                        end else if (i_cmd_num_vecs == '0) begin
                            r_state <= StDone;
                        end else begin
                            r_state <= StWaitX;
                        end
                    end
                end
                StLoadW: begin
                    if (i_w_valid) begin
                        r_arr_w <= i_w_data;
                        r_state <= StWlatch;
                    end
                end
                StWlatch: begin
                    r_state <= (r_remaining != '0) ? StWaitX : StDone;
                end
                StWaitX: begin
                    if (i_x_valid) begin
                        r_arr_x <= i_x_data;
                        r_cnt   <= LatW'(ARRAY_LAT - 1);
                        r_state <= StCompute;
                    end
                end
                // start stays high for the whole count, so ARRAY_LAT cycles in total
                StCompute: begin
                    if (r_cnt == '0) begin
                        r_state <= StCapture;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StCapture: begin
                    r_y_data  <= i_arr_y;
                    r_y_valid <= 1'b1;
                    r_err     <= r_err | ~i_arr_done;
                    r_state   <= StOut;
                end
                StOut: begin
                    if (i_y_ready) begin
                        r_y_valid <= 1'b0;
                        if (r_remaining != '0) begin
                            r_remaining <= r_remaining - 1'b1;
                        end
                        r_state <= (r_remaining <= CNT_W'(1)) ? StDone : StWaitX;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Handshake readies and strobes decode the registered state only.
    assign o_cmd_ready        = (r_state == StIdle);
    assign o_w_ready          = (r_state == StLoadW);
    assign o_x_ready          = (r_state == StWaitX);
    assign o_arr_load_weights = (r_state == StWlatch);
    assign o_arr_start        = (r_state == StCompute);
    assign o_job_done         = (r_state == StDone);
    assign o_busy             = (r_state != StIdle);
    assign o_y_valid          = r_y_valid;
    assign o_y_data           = r_y_data;
    assign o_arr_w            = r_arr_w;
    assign o_arr_x            = r_arr_x;
    assign o_err              = r_err;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Bench for systolic_array_sequencer: behavioural array model, table of x/y vectors,
// and a y scoreboard fed as x vectors are offered.
module tb_systolic_array_sequencer;
    import systolic_ctrl_pkg::*;

    localparam int DW  = 32;
    localparam int NN  = 4;
    localparam int LAT = 8;
    localparam int CW  = 16;
    localparam int XW  = NN * DW;
    localparam int WW  = NN * NN * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_load_w;
    logic [CW-1:0] cmd_num_vecs;
    logic          w_valid, w_ready;
    logic [WW-1:0] w_data;
    logic          x_valid, x_ready;
    logic [XW-1:0] x_data;
    logic          y_valid, y_ready;
    logic [XW-1:0] y_data;
    logic          arr_load_weights, arr_start;
    logic [WW-1:0] arr_w;
    logic [XW-1:0] arr_x, arr_y;
    logic          arr_done;
    logic          busy, job_done, err;

    always #5 clk = ~clk;

    systolic_array_sequencer #(
        .DATA_WIDTH(DW), .N(NN), .ARRAY_LAT(LAT), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_load_w(cmd_load_w),
        .i_cmd_num_vecs(cmd_num_vecs),
        .i_w_valid(w_valid), .o_w_ready(w_ready), .i_w_data(w_data),
        .i_x_valid(x_valid), .o_x_ready(x_ready), .i_x_data(x_data),
        .o_y_valid(y_valid), .i_y_ready(y_ready), .o_y_data(y_data),
        .o_arr_load_weights(arr_load_weights), .o_arr_start(arr_start),
        .o_arr_w(arr_w), .o_arr_x(arr_x), .i_arr_y(arr_y), .i_arr_done(arr_done),
        .o_busy(busy), .o_job_done(job_done), .o_err(err)
    );

    // Behavioural array: y[k] = sum_i x[i]*W[i][k], done after 2N start cycles.
    logic [WW-1:0] m_w;
    int            m_scnt;
    logic          m_done;
    logic          force_done_low;

    function automatic logic [XW-1:0] model_y(input logic [WW-1:0] w, input logic [XW-1:0] x);
        logic [XW-1:0]       y;
        logic [DW-1:0]       acc;
        logic [LaneBusW-1:0] xw;
        y  = '0;
        xw = LaneBusW'(x);
        for (int k = 0; k < NN; k++) begin
            acc = '0;
            for (int i = 0; i < NN; i++) begin
                acc = acc + lane_sel(w, i * NN + k) * lane_sel(xw, i);
            end
            y = y | (XW'(acc) << (k * DW));
        end
        return y;
    endfunction

    always @(posedge clk) begin
        if (arr_load_weights === 1'b1) m_w <= arr_w;
        if (reset) begin
            m_scnt <= 0;
            m_done <= 1'b0;
        end else if (arr_start) begin
            m_scnt <= m_scnt + 1;
            if (m_scnt == 0) m_done <= 1'b0;
            if (m_scnt + 1 >= 2 * NN) m_done <= 1'b1;
        end else begin
            m_scnt <= 0;
        end
    end

    assign arr_y    = model_y(m_w, arr_x);
    assign arr_done = m_done & ~force_done_low;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [XW-1:0] y;
    } vec_t;

    vec_t          tbl[8];
    logic [WW-1:0] w_ident, w_twos, w_mix;
    logic [XW-1:0] exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            lw_cnt = 0, st_cnt = 0, jd_cnt = 0;

    function automatic logic [XW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Event counters and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (arr_load_weights === 1'b1) lw_cnt <= lw_cnt + 1;
        if (arr_start === 1'b1) st_cnt <= st_cnt + 1;
        if (job_done === 1'b1) jd_cnt <= jd_cnt + 1;
        if (arr_load_weights === 1'b1 && arr_start === 1'b1) chk("lw_start_overlap", 1, 0);
        if (y_valid === 1'b1 && y_ready === 1'b1 && reset === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("y_unexpected", WW'(y_data), '0);
            end else begin
                chk("y_data", WW'(y_data), WW'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int which);
        case (which)
            0:       return cmd_ready;
            1:       return w_ready;
            default: return x_ready;
        endcase
    endfunction

    // Waits for ready with valid already up, then steps past the handshake edge.
    task automatic handshake(input int which, input string name);
        int t;
        t = 0;
        while (rdy(which) !== 1'b1 && t < 100) begin
            cyc();
            t++;
        end
        if (t >= 100) chk({name, "_timeout"}, 0, 1);
        cyc();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_flags"}, WW'({cmd_ready, busy, job_done, err, y_valid, arr_start,
                                  arr_load_weights, w_ready, x_ready}), WW'(9'b1_0000_0000));
        chk({tag, "_arr_w"}, arr_w, '0);
        chk({tag, "_arr_x"}, WW'(arr_x), '0);
        chk({tag, "_y_data"}, WW'(y_data), '0);
    endtask

    task automatic issue_cmd(input bit lw, input int num);
        cmd_load_w   = lw;
        cmd_num_vecs = CW'(num);
        cmd_valid    = 1'b1;
        handshake(0, "cmd");
        cmd_valid    = 1'b0;
    endtask

    task automatic do_vec(input int row, input bit stall);
        int            k, s0, t;
        bit            ok;
        logic [XW-1:0] hold;
        x_data  = tbl[row].x;
        x_valid = 1'b1;
        exp_q.push_back(tbl[row].y);
        handshake(2, "x");
        x_valid = 1'b0;
        s0 = st_cnt;
        if (stall) y_ready = 1'b0;
        k  = 0;
        ok = 1'b1;
        while (y_valid !== 1'b1 && k < 40) begin
            if (arr_x !== tbl[row].x) ok = 1'b0;
            cyc();
            k++;
        end
        chk("y_latency", k, LAT + 1);
        chk("start_cycles", st_cnt - s0, LAT);
        chk("arr_x_held", ok, 1);
        if (stall) begin
            hold = y_data;
            ok   = 1'b1;
            repeat (20) begin
                cyc();
                if (y_data !== hold || y_valid !== 1'b1 || x_ready !== 1'b0 || arr_start !== 1'b0)
                    ok = 1'b0;
            end
            chk("stall_hold", ok, 1);
            chk("stall_starts", st_cnt - s0, LAT);
            y_ready = 1'b1;
        end
        t = 0;
        while (y_valid === 1'b1 && t < 20) begin
            cyc();
            t++;
        end
        chk("y_pending", exp_q.size(), 0);
    endtask

    task automatic wait_done(input int jd0);
        int t;
        t = 0;
        while (jd_cnt == jd0 && t < 20) begin
            cyc();
            t++;
        end
        chk("job_done_count", jd_cnt - jd0, 1);
    endtask

    task automatic run_job(input bit lw, input logic [WW-1:0] w, input int first, input int num,
                           input int stall);
        int lw0, jd0;
        lw0 = lw_cnt;
        jd0 = jd_cnt;
        issue_cmd(lw, num);
        if (lw) begin
            w_data  = w;
            w_valid = 1'b1;
            handshake(1, "w");
            w_valid = 1'b0;
        end
        for (int v = 0; v < num; v++) do_vec(first + v, v == stall);
        wait_done(jd0);
        chk("load_w_pulses", lw_cnt - lw0, WW'(lw));
        chk("idle_after_job", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int jd0, s0, lw0;
        w_ident = '0;
        w_twos  = '0;
        w_mix   = '0;
        for (int i = 0; i < NN; i++) begin
            for (int j = 0; j < NN; j++) begin
                w_ident = w_ident | (WW'((i == j) ? 1 : 0) << ((i * NN + j) * DW));
                w_twos  = w_twos | (WW'(2) << ((i * NN + j) * DW));
                w_mix   = w_mix | (WW'(i * NN + j) << ((i * NN + j) * DW));
            end
        end
        tbl[0] = {pack4(1, 2, 3, 4), pack4(1, 2, 3, 4)};     // identity
        tbl[1] = {pack4(1, 2, 3, 4), pack4(20, 20, 20, 20)}; // all 2s
        tbl[2] = {pack4(1, 1, 1, 1), pack4(8, 8, 8, 8)};
        tbl[3] = {pack4(0, 0, 0, 5), pack4(10, 10, 10, 10)};
        tbl[4] = {pack4(3, 0, 0, 0), pack4(6, 6, 6, 6)};
        tbl[5] = {pack4(1, 0, 0, 1), pack4(12, 14, 16, 18)}; // W[i][k] = 4i+k
        tbl[6] = {pack4(2, 1, 0, 0), pack4(4, 7, 10, 13)};
        tbl[7] = {pack4(0, 0, 0, 0), pack4(0, 0, 0, 0)};

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_load_w = 1'b0; cmd_num_vecs = '0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;
        y_ready = 1'b1; force_done_low = 1'b0;
        repeat (3) cyc();
        chk_reset_state("reset");
        reset = 1'b0;
        cyc();

        run_job(1'b1, w_ident, 0, 1, -1);
        run_job(1'b1, w_twos, 1, 1, -1);
        run_job(1'b0, '0, 2, 3, 1);

        // Zero-length job: handshake cycle, then the DONE cycle, no array activity.
        jd0 = jd_cnt; s0 = st_cnt; lw0 = lw_cnt;
        issue_cmd(1'b0, 0);
        chk("zero_job_done", job_done, 1);
        cyc();
        chk("zero_job_done_len", job_done, 0);
        chk("zero_idle", busy, 0);
        chk("zero_starts", st_cnt - s0, 0);
        chk("zero_loads", lw_cnt - lw0, 0);
        chk("zero_done_count", jd_cnt - jd0, 1);

        // Reset during COMPUTE of the second vector.
        issue_cmd(1'b0, 3);
        do_vec(2, 1'b0);
        x_data  = tbl[3].x;
        x_valid = 1'b1;
        handshake(2, "x_abort");
        x_valid = 1'b0;
        repeat (3) cyc();
        chk("abort_in_compute", arr_start, 1);
        jd0   = jd_cnt;
        reset = 1'b1;
        cyc();
        chk_reset_state("abort");
        reset = 1'b0;
        repeat (5) cyc();
        chk("abort_no_job_done", jd_cnt - jd0, 0);
        run_job(1'b1, w_mix, 5, 1, -1);

        // Busy-time command is ignored; missing arr_done sets a sticky err.
        chk("err_clear", err, 0);
        jd0 = jd_cnt;
        issue_cmd(1'b0, 1);
        cmd_num_vecs = CW'(5);
        cmd_valid    = 1'b1;
        cyc();
        chk("busy_cmd_ready", cmd_ready, 0);
        cyc();
        cmd_valid = 1'b0;
        force_done_low = 1'b1;
        do_vec(6, 1'b0);
        force_done_low = 1'b0;
        wait_done(jd0);
        chk("err_set", err, 1);
        repeat (4) cyc();
        chk("busy_cmd_ignored", busy, 0);
        run_job(1'b0, '0, 6, 1, -1);
        chk("err_sticky", err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
